// File: rtl/wb_axi_pkg.sv
// Shared types and constants for the pipelined Wishbone to AXI4-Lite bridge.
package wb_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DRAIN = 2'b11
    } state_e;

    // A response completes the Wishbone cycle with ack only for OKAY or EXOKAY.
    function automatic logic resp_is_ok(input logic [1:0] resp);
        return (resp == RESP_OKAY) || (resp == RESP_EXOKAY);
    endfunction

endpackage

// File: rtl/axi_valid_hold.sv
// One-bit AXI valid register: raised on request, held until its handshake.
module axi_valid_hold (
    input  logic clk,
    input  logic rst_n,
    input  logic i_set,
    input  logic i_ready,
    output logic o_valid
);

    logic r_valid;

    // Set wins; otherwise valid stays up until the ready handshake consumes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (i_set) begin
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;

endmodule

// File: rtl/wb_to_axi4lite_pipe_bridge.sv
// Pipelined Wishbone B4 slave to AXI4-Lite master bridge with a single issue
// slot and up to MAX_OUTSTANDING transactions of one direction in flight.
module wb_to_axi4lite_pipe_bridge
    import wb_axi_pkg::*;
#(
    parameter int         DW              = 32,
    parameter int         AW              = 32,
    parameter int         MAX_OUTSTANDING = 4,
    parameter logic [2:0] PROT            = 3'b000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            wb_rty_o,
    output logic            wb_stall_o,
    output logic            m_axi_awvalid,
    input  logic            m_axi_awready,
    output logic [AW-1:0]   m_axi_awaddr,
    output logic [2:0]      m_axi_awprot,
    output logic            m_axi_wvalid,
    input  logic            m_axi_wready,
    output logic [DW-1:0]   m_axi_wdata,
    output logic [DW/8-1:0] m_axi_wstrb,
    input  logic            m_axi_bvalid,
    output logic            m_axi_bready,
    input  logic [1:0]      m_axi_bresp,
    output logic            m_axi_arvalid,
    input  logic            m_axi_arready,
    output logic [AW-1:0]   m_axi_araddr,
    output logic [2:0]      m_axi_arprot,
    input  logic            m_axi_rvalid,
    output logic            m_axi_rready,
    input  logic [DW-1:0]   m_axi_rdata,
    input  logic [1:0]      m_axi_rresp
);

    localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] CNT_0   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_1   = {{(CW-1){1'b0}}, 1'b1};

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW/8-1:0] r_wstrb;
    logic [DW-1:0]   r_rdata;
    logic            r_ack;
    logic            r_err;

    logic w_awvalid;
    logic w_wvalid;
    logic w_arvalid;
    logic w_slot_busy;
    logic w_stall;
    logic w_accept;
    logic w_bready;
    logic w_rready;
    logic w_b_hs;
    logic w_r_hs;
    logic w_resp_hs;
    logic [1:0] w_resp;
    logic w_resp_ok;

    // The slot holds a request until every channel it needs has handshaken;
    // a response can only be outstanding for an already-accepted request,
    // so the counter alone already covers the slot for idle detection.
    assign w_slot_busy = w_awvalid | w_wvalid | w_arvalid;
    assign w_stall     = w_slot_busy
                       | (r_cnt == MAX_CNT)
                       | (r_state == ST_DRAIN)
                       | ((r_state == ST_READ)  &  wb_we_i)
                       | ((r_state == ST_WRITE) & ~wb_we_i);
    assign w_accept    = wb_cyc_i & wb_stb_i & ~w_stall;

    assign w_bready  = (r_state == ST_WRITE) | (r_state == ST_DRAIN);
    assign w_rready  = (r_state == ST_READ)  | (r_state == ST_DRAIN);
    assign w_b_hs    = m_axi_bvalid & w_bready;
    assign w_r_hs    = m_axi_rvalid & w_rready;
    assign w_resp_hs = w_b_hs | w_r_hs;
    assign w_resp    = w_r_hs ? m_axi_rresp : m_axi_bresp;
    assign w_resp_ok = resp_is_ok(w_resp);

    axi_valid_hold u_aw_hold (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .i_set   (w_accept & wb_we_i),
        .i_ready (m_axi_awready),
        .o_valid (w_awvalid)
    );

    axi_valid_hold u_w_hold (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .i_set   (w_accept & wb_we_i),
        .i_ready (m_axi_wready),
        .o_valid (w_wvalid)
    );

    axi_valid_hold u_ar_hold (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .i_set   (w_accept & ~wb_we_i),
        .i_ready (m_axi_arready),
        .o_valid (w_arvalid)
    );

    // Outstanding count: acceptance adds one, any response removes one.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_accept && !w_resp_hs) begin
            w_cnt_nxt = r_cnt + CNT_1;
        end else if (!w_accept && w_resp_hs) begin
            w_cnt_nxt = r_cnt - CNT_1;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Register the outstanding count.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_cnt <= CNT_0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Capture the accepted request into the issue slot.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_addr  <= {AW{1'b0}};
            r_wdata <= {DW{1'b0}};
            r_wstrb <= {(DW/8){1'b0}};
        end else if (w_accept) begin
            r_addr  <= wb_adr_i;
            r_wdata <= wb_dat_i;
            r_wstrb <= wb_sel_i;
        end else begin
            r_addr  <= r_addr;
            r_wdata <= r_wdata;
            r_wstrb <= r_wstrb;
        end
    end

    // Direction FSM plus the registered ack/err/read-data it qualifies.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= {DW{1'b0}};
        end else begin
            // Responses arriving while draining are swallowed silently.
            r_ack <= w_resp_hs &  w_resp_ok & (r_state != ST_DRAIN);
            r_err <= w_resp_hs & ~w_resp_ok & (r_state != ST_DRAIN);
            if (w_r_hs && w_resp_ok && (r_state == ST_READ)) begin
                r_rdata <= m_axi_rdata;
            end else begin
                r_rdata <= r_rdata;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= wb_we_i ? ST_WRITE : ST_READ;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (w_cnt_nxt == CNT_0) begin
                        r_state <= ST_IDLE;
                    end else if (!wb_cyc_i) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_DRAIN: begin
                    if ((r_cnt == CNT_0) && !w_slot_busy) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wb_dat_o      = r_rdata;
    assign wb_ack_o      = r_ack;
    assign wb_err_o      = r_err;
    assign wb_rty_o      = 1'b0;
    assign wb_stall_o    = w_stall;

    assign m_axi_awvalid = w_awvalid;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awprot  = PROT;
    assign m_axi_wvalid  = w_wvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_bready  = w_bready;
    assign m_axi_arvalid = w_arvalid;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arprot  = PROT;
    assign m_axi_rready  = w_rready;

endmodule

// File: tb/tb_wb_to_axi4lite_pipe_bridge.sv
// Directed bench for the pipelined Wishbone to AXI4-Lite bridge.
module tb_wb_to_axi4lite_pipe_bridge;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic        wb_stall_o;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;

    int n_assert = 0;
    int n_fail   = 0;

    wb_to_axi4lite_pipe_bridge #(
        .DW(32), .AW(32), .MAX_OUTSTANDING(4), .PROT(3'b000)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .wb_rty_o(wb_rty_o), .wb_stall_o(wb_stall_o),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_bresp(m_axi_bresp),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Present one request, wait (bounded) for stall low, let it be accepted.
    task automatic wb_issue(input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
        int n;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        #1;
        n = 0;
        while (wb_stall_o && n < 20) begin
            step();
            n++;
        end
        check("issue_stall", {63'd0, wb_stall_o}, 64'd0);
        step();
        wb_stb_i = 1'b0;
    endtask

    // Full read with arready high and the R response one cycle after AR.
    task automatic read_txn(input logic [31:0] adr, input logic [31:0] rdata,
                            input logic [1:0] resp, input logic exp_ack,
                            input logic exp_err, input logic [31:0] exp_dat);
        wb_issue(1'b0, adr, 32'h0000_0000, 4'b0000);
        check("rd_arvalid", {63'd0, m_axi_arvalid}, 64'd1);
        check("rd_araddr", {32'd0, m_axi_araddr}, {32'd0, adr});
        step();
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = rdata;
        m_axi_rresp  = resp;
        step();
        m_axi_rvalid = 1'b0;
        check("rd_ack", {63'd0, wb_ack_o}, {63'd0, exp_ack});
        check("rd_err", {63'd0, wb_err_o}, {63'd0, exp_err});
        check("rd_dat", {32'd0, wb_dat_o}, {32'd0, exp_dat});
        check("rd_rty", {63'd0, wb_rty_o}, 64'd0);
        step();
        check("rd_ack_pulse", {62'd0, wb_ack_o, wb_err_o}, 64'd0);
    endtask

    initial begin
        wb_rst_ni = 1'b0;
        wb_adr_i = 32'h0; wb_dat_i = 32'h0; wb_sel_i = 4'h0;
        wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        m_axi_rvalid = 1'b0; m_axi_rdata = 32'h0; m_axi_rresp = 2'b00;
        #2;
        // Reset state
        check("rst_valids", {61'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 64'd0);
        check("rst_ack_err", {62'd0, wb_ack_o, wb_err_o}, 64'd0);
        check("rst_stall", {63'd0, wb_stall_o}, 64'd0);
        check("rst_dat", {32'd0, wb_dat_o}, 64'd0);
        check("rst_readies", {62'd0, m_axi_bready, m_axi_rready}, 64'd0);
        step();
        step();
        wb_rst_ni = 1'b1;
        step();

        // Single OKAY read
        read_txn(32'h0000_0100, 32'hDEAD_BEEF, 2'b00, 1'b1, 1'b0, 32'hDEAD_BEEF);
        check("t1_idle_rready", {63'd0, m_axi_rready}, 64'd0);
        check("t1_stall", {63'd0, wb_stall_o}, 64'd0);

        // Four pipelined writes with B held off
        wb_issue(1'b1, 32'h0000_0200, 32'h1111_2222, 4'b0101);
        check("t2_awvalid", {62'd0, m_axi_awvalid, m_axi_wvalid}, 64'd3);
        check("t2_awaddr", {32'd0, m_axi_awaddr}, 64'h200);
        check("t2_wdata", {32'd0, m_axi_wdata}, 64'h1111_2222);
        check("t2_wstrb", {60'd0, m_axi_wstrb}, 64'h5);
        check("t2_prot", {58'd0, m_axi_awprot, m_axi_arprot}, 64'd0);
        wb_issue(1'b1, 32'h0000_0204, 32'h3333_4444, 4'b1111);
        wb_issue(1'b1, 32'h0000_0208, 32'h5555_6666, 4'b1111);
        wb_issue(1'b1, 32'h0000_020C, 32'h7777_8888, 4'b1111);
        check("t2_slot_stall", {63'd0, wb_stall_o}, 64'd1);
        wb_stb_i = 1'b1;
        step();
        check("t2_full_stall", {63'd0, wb_stall_o}, 64'd1);
        check("t2_slot_free", {63'd0, m_axi_awvalid}, 64'd0);
        step();
        check("t2_no_fifth", {63'd0, m_axi_awvalid}, 64'd0);
        wb_stb_i = 1'b0;
        m_axi_bvalid = 1'b1;
        step();
        check("t2_ack1", {62'd0, wb_ack_o, wb_err_o}, 64'd2);
        check("t2_stall_drop", {63'd0, wb_stall_o}, 64'd0);
        step();
        check("t2_ack2", {62'd0, wb_ack_o, wb_err_o}, 64'd2);
        step();
        check("t2_ack3", {62'd0, wb_ack_o, wb_err_o}, 64'd2);
        step();
        check("t2_ack4", {62'd0, wb_ack_o, wb_err_o}, 64'd2);
        m_axi_bvalid = 1'b0;
        step();
        check("t2_ack_end", {63'd0, wb_ack_o}, 64'd0);
        check("t2_idle_bready", {63'd0, m_axi_bready}, 64'd0);

        // AW delayed while W handshakes at once
        m_axi_awready = 1'b0;
        wb_issue(1'b1, 32'h0000_0300, 32'hCAFE_F00D, 4'b1100);
        check("t3_both_valid", {62'd0, m_axi_awvalid, m_axi_wvalid}, 64'd3);
        step();
        check("t3_w_dropped", {62'd0, m_axi_awvalid, m_axi_wvalid}, 64'd2);
        check("t3_stall_a", {63'd0, wb_stall_o}, 64'd1);
        step();
        check("t3_aw_held", {62'd0, m_axi_awvalid, m_axi_wvalid}, 64'd2);
        check("t3_stall_b", {63'd0, wb_stall_o}, 64'd1);
        m_axi_awready = 1'b1;
        step();
        check("t3_aw_done", {63'd0, m_axi_awvalid}, 64'd0);
        check("t3_slot_free", {63'd0, wb_stall_o}, 64'd0);
        m_axi_bvalid = 1'b1;
        step();
        m_axi_bvalid = 1'b0;
        check("t3_ack", {62'd0, wb_ack_o, wb_err_o}, 64'd2);
        step();

        // Read presented while a write is outstanding
        wb_issue(1'b1, 32'h0000_0400, 32'h0404_0404, 4'b1111);
        step();
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0000_0404;
        #1;
        check("t4_mix_stall_a", {63'd0, wb_stall_o}, 64'd1);
        step();
        check("t4_mix_stall_b", {63'd0, wb_stall_o}, 64'd1);
        check("t4_no_ar", {63'd0, m_axi_arvalid}, 64'd0);
        m_axi_bvalid = 1'b1;
        step();
        m_axi_bvalid = 1'b0;
        check("t4_b_ack", {63'd0, wb_ack_o}, 64'd1);
        check("t4_stall_clear", {63'd0, wb_stall_o}, 64'd0);
        step();
        wb_stb_i = 1'b0;
        check("t4_ar_issued", {63'd0, m_axi_arvalid}, 64'd1);
        check("t4_araddr", {32'd0, m_axi_araddr}, 64'h404);
        step();
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h1234_5678; m_axi_rresp = 2'b00;
        step();
        m_axi_rvalid = 1'b0;
        check("t4_rd_ack", {62'd0, wb_ack_o, wb_err_o}, 64'd2);
        check("t4_rd_dat", {32'd0, wb_dat_o}, 64'h1234_5678);
        step();

        // SLVERR then DECERR reads
        read_txn(32'h0000_0500, 32'h5555_5555, 2'b10, 1'b0, 1'b1, 32'h1234_5678);
        read_txn(32'h0000_0504, 32'h6666_6666, 2'b11, 1'b0, 1'b1, 32'h1234_5678);

        // Two reads in flight, CYC dropped, responses drained
        wb_issue(1'b0, 32'h0000_0600, 32'h0, 4'h0);
        wb_issue(1'b0, 32'h0000_0604, 32'h0, 4'h0);
        wb_cyc_i = 1'b0;
        step();
        check("t6_drain_stall", {63'd0, wb_stall_o}, 64'd1);
        check("t6_drain_readies", {62'd0, m_axi_bready, m_axi_rready}, 64'd3);
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h7777_7777; m_axi_rresp = 2'b00;
        step();
        check("t6_silent1", {62'd0, wb_ack_o, wb_err_o}, 64'd0);
        step();
        m_axi_rvalid = 1'b0;
        check("t6_silent2", {62'd0, wb_ack_o, wb_err_o}, 64'd0);
        step();
        check("t6_idle_readies", {62'd0, m_axi_bready, m_axi_rready}, 64'd0);
        check("t6_idle_stall", {63'd0, wb_stall_o}, 64'd0);
        check("t6_dat_kept", {32'd0, wb_dat_o}, 64'h1234_5678);
        read_txn(32'h0000_0700, 32'hA5A5_A5A5, 2'b01, 1'b1, 1'b0, 32'hA5A5_A5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_to_axi4lite_pipe_bridge.md
# wb_to_axi4lite_pipe_bridge

Pipelined Wishbone B4 slave to AXI4-Lite master bridge: next generation of the single-transfer WB-to-AXI4-Lite bridge. It accepts back-to-back Wishbone pipelined requests and keeps up to MAX_OUTSTANDING AXI transactions in flight. It issues AW and W independently, maps AXI responses to ack/err, and drains orphaned responses when the master drops CYC. It sits between a pipelined Wishbone interconnect and an AXI4-Lite peripheral fabric.

## Interface
- DW, 32, data width (32 or 64)
- AW, 32, address width
- MAX_OUTSTANDING, 4, max in-flight AXI transactions (1..15)
- PROT, 3'b000, constant driven on m_axi_awprot/m_axi_arprot
- Ports:
  - wb_clk_i  in  1  clock; the only clock
  - wb_rst_ni  in  1  reset, asynchronous, active-low
  - wb_adr_i  in  AW  address
  - wb_dat_i  in  DW  write data
  - wb_sel_i  in  DW/8  byte select
  - wb_we_i  in  1  write enable
  - wb_cyc_i  in  1  cycle
  - wb_stb_i  in  1  strobe
  - wb_dat_o  out  DW  read data, registered
  - wb_ack_o  out  1  OKAY/EXOKAY response
  - wb_err_o  out  1  SLVERR/DECERR response
  - wb_rty_o  out  1  tied 0
  - wb_stall_o  out  1  pipeline stall
  - m_axi_aw{valid,ready,addr,prot}, m_axi_w{valid,ready,data,strb}, m_axi_b{valid,ready,resp}, m_axi_ar{valid,ready,addr,prot}, m_axi_r{valid,ready,data,resp}: standard AXI4-Lite; widths AW, DW, DW/8, 2, 3

## Operation
- Request is accepted when wb_cyc_i & wb_stb_i & ~wb_stall_o. On acceptance, address, data and strb are latched into an issue slot. awvalid+wvalid (write) or arvalid (read) rise the next cycle.
- awvalid and wvalid each drop independently after their own handshake. The slot frees when all required handshakes are done. Valid is never withdrawn before its handshake, even if CYC drops.
- wstrb = latched wb_sel_i.
- Outstanding counter cnt (width $clog2(MAX_OUTSTANDING+1)):
  - +1 on acceptance; −1 on B or R handshake; simultaneous +1/−1 leaves it unchanged.
- wb_stall_o = slot busy | cnt==MAX_OUTSTANDING | state==DRAIN | (state==READ & wb_we_i) | (state==WRITE & ~wb_we_i). Reads and writes are therefore never mixed in flight, and response order equals request order.
- bready = (state==WRITE | DRAIN); rready = (state==READ | DRAIN). The bridge never back-pressures a response.
- Response handling:
  - resp[1]==0: ack next cycle; wb_dat_o loaded from rdata on reads.
  - resp[1]==1: err next cycle.
  - Ack and err are one-cycle pulses, mutually exclusive.
- FSM:
  - IDLE→READ/WRITE on acceptance with wb_we_i=0/1.
  - READ/WRITE→IDLE when cnt returns to 0 with no same-cycle acceptance.
  - READ/WRITE→DRAIN when wb_cyc_i falls while cnt>0 or slot busy.
  - DRAIN→IDLE when cnt==0 and slot free.
  - In DRAIN, responses are consumed with no ack/err.
- Reset: all valids 0, ack/err 0, stall 0, wb_dat_o 0, cnt 0, state IDLE. Asynchronous assertion mid-transaction abandons everything; downstream must be reset together.

## Timing
- Acceptance at cycle 0 → AXI valid at cycle 1. With ready high, handshake at cycle 1.
- Response handshake at cycle k → ack/err at cycle k+1.
- Minimum read latency: 3 cycles (slave returns rvalid one cycle after arready).
- Throughput: one request per 2 cycles. The slot is busy during the cycle its valid is presented; combinational slot bypass is not allowed.
- All outputs are registered except wb_stall_o, ready signals and AXI payload, which are driven from the slot registers.

## Structure
- Package wb_axi_pkg:
  - AXI resp constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - State enum {ST_IDLE, ST_READ, ST_WRITE, ST_DRAIN}.
- Sub-module axi_valid_hold: one-bit valid-until-handshake register, instantiated for AW, W and AR.

## Test plan
- Single read, arready=1, rvalid two cycles later with rdata=32'hDEADBEEF, OKAY → one ack, wb_dat_o=32'hDEADBEEF, cnt back to 0.
- 4 pipelined writes (MAX_OUTSTANDING=4), bvalid held low → stall after the 4th acceptance; release 4 B responses → 4 acks in order, stall drops.
- awready held low 3 cycles while wready=1 → wvalid drops after its handshake, awvalid stays high, slot frees only after AW handshake.
- Write outstanding then read presented → stall until the B response; then read accepted.
- Read with rresp=2'b10, then read with rresp=2'b11 → two err pulses, no ack, wb_rty_o=0.
- 2 reads outstanding, CYC dropped → state DRAIN, stall=1, both R consumed silently, IDLE; new read accepted normally.
